udma_lin_ch_alloc: RTL and testbench

- Dynamic allocator for uDMA linear channels.
- Replaces the fixed per-peripheral channel-ID map with a runtime pool: peripherals request a channel, receive a free channel ID, and release it when done.
- Sits between peripheral channel front-ends and the uDMA core channel muxes; exposes an ownership table the core uses to steer channel traffic.
- Parametrised in peripheral count, channel count and per-peripheral cap.

---
 rtl/udma_lin_ch_alloc.sv | 207 ++++++++++++++++++++
 tb/tb_udma_lin_ch_alloc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_lin_ch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : udma_lin_ch_alloc
// Purpose  : Runtime pool allocator for uDMA linear channels. Peripherals
//            request a channel, receive the lowest free channel ID through a
//            round-robin arbiter, and hand it back by per-channel or bulk
//            release. Exposes the ownership table used for channel steering.
// Revision : 1.0 - initial release
// ============================================================================
module udma_lin_ch_alloc #(
  parameter int N_PERIPHS      = 8,
  parameter int N_CHANNELS     = 16,
  parameter int MAX_PER_PERIPH = 4,
  parameter int CH_W           = $clog2(N_CHANNELS),
  parameter int PER_W          = $clog2(N_PERIPHS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_PERIPHS-1:0]               req_i,
  output logic [N_PERIPHS-1:0]               gnt_o,
  output logic [CH_W-1:0]                    gnt_ch_o,
  input  logic [N_PERIPHS-1:0]               rel_i,
  input  logic [N_PERIPHS*CH_W-1:0]          rel_ch_i,
  input  logic [N_PERIPHS-1:0]               rel_all_i,
  output logic [N_CHANNELS-1:0]              ch_busy_o,
  output logic [N_CHANNELS*PER_W-1:0]        ch_owner_o,
  output logic [$clog2(N_CHANNELS+1)-1:0]    free_cnt_o,
  output logic                               err_o
);

  localparam int FC_W = $clog2(N_CHANNELS + 1);
  localparam int OC_W = $clog2(MAX_PER_PERIPH + 1);

  logic [N_PERIPHS-1:0]  r_gnt;
  logic [CH_W-1:0]       r_gnt_ch;
  logic [N_CHANNELS-1:0] r_busy;
  logic [PER_W-1:0]      r_owner     [N_CHANNELS];
  logic [OC_W-1:0]       r_owned_cnt [N_PERIPHS];
  logic [FC_W-1:0]       r_free_cnt;
  logic [PER_W-1:0]      r_ptr;
  logic                  r_err;

  logic [N_PERIPHS-1:0]  w_elig;
  logic                  w_gnt_vld;
  logic [PER_W-1:0]      w_gnt_per;
  logic [N_PERIPHS-1:0]  w_gnt;
  logic [CH_W-1:0]       w_free_ch;
  logic [N_CHANNELS-1:0] w_freed;
  logic                  w_err;
  logic [OC_W-1:0]       w_freed_per [N_PERIPHS];
  logic [FC_W-1:0]       w_freed_tot;

  // A peripheral competes only if it asks, is under its cap, was not just
  // granted (its request is still high while it reacts) and is not bulk-freeing.
  generate
    for (genvar p = 0; p < N_PERIPHS; p++) begin : g_elig
      assign w_elig[p] = req_i[p] & ~r_gnt[p] & ~rel_all_i[p] &
                         (r_owned_cnt[p] < OC_W'(MAX_PER_PERIPH));
    end
  endgenerate

  // Round-robin pick of the first eligible peripheral at or after the pointer.
  always_comb begin
    logic [PER_W-1:0] v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_per = '0;
    v_idx     = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      v_idx = PER_W'((int'(r_ptr) + k) % N_PERIPHS);
      if (!w_gnt_vld && w_elig[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_per = v_idx;
      end
    end
    // Only registered-free channels are handed out, so same-cycle releases
    // never feed a grant.
    if (r_free_cnt == '0) begin
      w_gnt_vld = 1'b0;
    end
    w_gnt = '0;
    if (w_gnt_vld) begin
      w_gnt[w_gnt_per] = 1'b1;
    end
  end

  // Lowest-index channel that is free in the registered table.
  always_comb begin
    w_free_ch = '0;
    for (int c = N_CHANNELS - 1; c >= 0; c--) begin
      if (!r_busy[c]) begin
        w_free_ch = CH_W'(c);
      end
    end
  end

  // Decode releases: bulk release wins over a single release of the same
  // peripheral; a single release must name a busy channel it owns.
  always_comb begin
    logic v_legal;
    w_freed = '0;
    w_err   = 1'b0;
    v_legal = 1'b0;
    for (int p = 0; p < N_PERIPHS; p++) begin
      v_legal = 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (r_busy[c] && (r_owner[c] == PER_W'(p))) begin
          if (rel_all_i[p]) begin
            w_freed[c] = 1'b1;
          end else if (rel_i[p] && (rel_ch_i[p*CH_W +: CH_W] == CH_W'(c))) begin
            w_freed[c] = 1'b1;
            v_legal    = 1'b1;
          end
        end
      end
      if (rel_i[p] && !rel_all_i[p] && !v_legal) begin
        w_err = 1'b1;
      end
    end
  end

  // Tally freed channels overall and per owning peripheral.
  always_comb begin
    w_freed_tot = '0;
    for (int p = 0; p < N_PERIPHS; p++) begin
      w_freed_per[p] = '0;
    end
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (w_freed[c]) begin
        w_freed_tot          = w_freed_tot + 1'b1;
        w_freed_per[r_owner[c]] = w_freed_per[r_owner[c]] + 1'b1;
      end
    end
  end

  // Allocation table, counters, arbiter pointer and grant/error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt      <= '0;
      r_gnt_ch   <= '0;
      r_busy     <= '0;
      r_free_cnt <= FC_W'(N_CHANNELS);
      r_ptr      <= '0;
      r_err      <= 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) begin
        r_owner[c] <= '0;
      end
      for (int p = 0; p < N_PERIPHS; p++) begin
        r_owned_cnt[p] <= '0;
      end
    end else begin
      r_gnt      <= w_gnt;
      r_gnt_ch   <= w_gnt_vld ? w_free_ch : '0;
      r_err      <= w_err;
      r_free_cnt <= r_free_cnt - FC_W'(w_gnt_vld) + w_freed_tot;
      if (w_gnt_vld) begin
        r_ptr <= PER_W'((int'(w_gnt_per) + 1) % N_PERIPHS);
      end
      // A granted channel is free in the registered table, so it can never
      // also be in the freed set.
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (w_freed[c]) begin
          r_busy[c]  <= 1'b0;
          r_owner[c] <= '0;
        end else if (w_gnt_vld && (w_free_ch == CH_W'(c))) begin
          r_busy[c]  <= 1'b1;
          r_owner[c] <= w_gnt_per;
        end
      end
      for (int p = 0; p < N_PERIPHS; p++) begin
        r_owned_cnt[p] <= r_owned_cnt[p] + OC_W'(w_gnt[p]) - w_freed_per[p];
      end
    end
  end

  generate
    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_owner
      assign ch_owner_o[c*PER_W +: PER_W] = r_owner[c];
    end
  endgenerate

  assign gnt_o      = r_gnt;
  assign gnt_ch_o   = r_gnt_ch;
  assign ch_busy_o  = r_busy;
  assign free_cnt_o = r_free_cnt;
  assign err_o      = r_err;

`ifndef SYNTHESIS
  int w_owned_sum;

  // Total of per-peripheral ownership counters, for the bookkeeping invariant.
  always_comb begin
    w_owned_sum = 0;
    for (int p = 0; p < N_PERIPHS; p++) begin
      w_owned_sum = w_owned_sum + int'(r_owned_cnt[p]);
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_free_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(free_cnt_o) == N_CHANNELS - $countones(ch_busy_o));
  a_owned_sum: assert property (@(posedge clk_i) disable iff (rst_i)
    w_owned_sum == $countones(ch_busy_o));
`endif

endmodule
`default_nettype wire

// File: tb/tb_udma_lin_ch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_udma_lin_ch_alloc
// Purpose  : Self-checking bench for udma_lin_ch_alloc: directed scenarios
//            plus randomized traffic against a channel-ownership model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_lin_ch_alloc;

  localparam int NP    = 8;
  localparam int NC    = 16;
  localparam int MAXP  = 4;
  localparam int CH_W  = $clog2(NC);
  localparam int PER_W = $clog2(NP);
  localparam int FC_W  = $clog2(NC + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NP-1:0]          req = '0;
  logic [NP-1:0]          rel = '0;
  logic [NP*CH_W-1:0]     rel_ch = '0;
  logic [NP-1:0]          rel_all = '0;
  logic [NP-1:0]          gnt;
  logic [CH_W-1:0]        gnt_ch;
  logic [NC-1:0]          busy;
  logic [NC*PER_W-1:0]    owner;
  logic [FC_W-1:0]        free_cnt;
  logic                   err;

  int n_checks = 0;
  int n_errors = 0;

  // model state: owner per channel (-1 = free), arbiter pointer, last grantee
  int            m_owner [NC];
  int            m_ptr;
  int            m_last;
  logic [NP-1:0] e_gnt;
  int            e_gnt_ch;
  logic          e_err;

  udma_lin_ch_alloc #(
    .N_PERIPHS(NP), .N_CHANNELS(NC), .MAX_PER_PERIPH(MAXP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .gnt_ch_o(gnt_ch),
    .rel_i(rel), .rel_ch_i(rel_ch), .rel_all_i(rel_all),
    .ch_busy_o(busy), .ch_owner_o(owner), .free_cnt_o(free_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  // Apply the allocator rules to the current inputs to get the next state.
  task automatic model_step();
    int free;
    int owned [NP];
    int nown [NC];
    int gp, gc, p, c;
    if (rst) begin
      for (int i = 0; i < NC; i++) m_owner[i] = -1;
      m_ptr = 0; m_last = -1; e_gnt = '0; e_gnt_ch = 0; e_err = 1'b0;
      return;
    end
    free = 0;
    for (int i = 0; i < NP; i++) owned[i] = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_owner[i] < 0) free++;
      else owned[m_owner[i]]++;
    end
    gp = -1; gc = 0;
    if (free > 0) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (gp < 0 && req[p] && p != m_last && !rel_all[p] && owned[p] < MAXP) gp = p;
      end
    end
    if (gp >= 0) begin
      for (int i = NC - 1; i >= 0; i--) if (m_owner[i] < 0) gc = i;
    end
    e_err = 1'b0;
    nown = m_owner;
    for (int i = 0; i < NP; i++) begin
      if (rel_all[i]) begin
        for (int j = 0; j < NC; j++) if (m_owner[j] == i) nown[j] = -1;
      end else if (rel[i]) begin
        c = int'(rel_ch[i*CH_W +: CH_W]);
        if (m_owner[c] == i) nown[c] = -1;
        else e_err = 1'b1;
      end
    end
    if (gp >= 0) begin
      nown[gc] = gp; m_ptr = (gp + 1) % NP; m_last = gp;
      e_gnt = '0; e_gnt[gp] = 1'b1; e_gnt_ch = gc;
    end else begin
      m_last = -1; e_gnt = '0; e_gnt_ch = 0;
    end
    m_owner = nown;
  endtask

  function automatic logic [NC-1:0] exp_busy();
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = (m_owner[i] >= 0);
    return v;
  endfunction

  function automatic logic [NC*PER_W-1:0] exp_owner();
    logic [NC*PER_W-1:0] v = '0;
    for (int i = 0; i < NC; i++) if (m_owner[i] >= 0) v[i*PER_W +: PER_W] = PER_W'(m_owner[i]);
    return v;
  endfunction

  function automatic int exp_free();
    int n = 0;
    for (int i = 0; i < NC; i++) if (m_owner[i] < 0) n++;
    return n;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic grant_to(input int p);
    req = '0; req[p] = 1'b1; step();
    req = '0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rel = '0; rel_all = '0; rel_ch = '0;
    step(); step();
    n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    n_checks++; if (gnt_ch !== '0) begin n_errors++; $display("FAIL reset_gnt_ch got=%0d exp=0", gnt_ch); end
    n_checks++; if (busy !== '0) begin n_errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
    n_checks++; if (owner !== '0) begin n_errors++; $display("FAIL reset_owner got=%h exp=0", owner); end
    n_checks++; if (free_cnt !== FC_W'(NC)) begin n_errors++; $display("FAIL reset_free got=%0d exp=%0d", free_cnt, NC); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    req = 8'h01; step();
    n_checks++; if (gnt !== 8'h01) begin n_errors++; $display("FAIL single_gnt got=%h exp=01", gnt); end
    n_checks++; if (gnt_ch !== 4'd0) begin n_errors++; $display("FAIL single_ch got=%0d exp=0", gnt_ch); end
    n_checks++; if (busy[0] !== 1'b1) begin n_errors++; $display("FAIL single_busy got=%b exp=1", busy[0]); end
    n_checks++; if (free_cnt !== FC_W'(15)) begin n_errors++; $display("FAIL single_free got=%0d exp=15", free_cnt); end
    req = '0; step();
    n_checks++; if (gnt !== '0) begin n_errors++; $display("FAIL single_pulse got=%h exp=0", gnt); end
  endtask

  task automatic test_rotate();
    rst = 1'b1; step(); rst = 1'b0;
    req = 8'h0F;
    for (int k = 0; k < NC; k++) begin
      step();
      n_checks++;
      if (gnt !== NP'(1 << (k % 4)) || gnt_ch !== CH_W'(k)) begin
        n_errors++; $display("FAIL rotate_gnt k=%0d got=%h/%0d exp=%h/%0d", k, gnt, gnt_ch, 1 << (k % 4), k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (gnt !== '0 || free_cnt !== '0) begin
        n_errors++; $display("FAIL rotate_empty got gnt=%h free=%0d exp gnt=0 free=0", gnt, free_cnt);
      end
    end
    req = '0; step();
  endtask

  task automatic test_release_regrant();
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) grant_to(0);
    for (int k = 0; k < 4; k++) grant_to(2);
    for (int k = 0; k < 4; k++) grant_to(3);
    for (int k = 0; k < 4; k++) grant_to(4);
    n_checks++; if (free_cnt !== '0) begin n_errors++; $display("FAIL fill_free got=%0d exp=0", free_cnt); end
    // peripheral 2 returns channel 5 while peripheral 1 waits
    req = 8'h02; rel = 8'h04; rel_ch[2*CH_W +: CH_W] = 4'd5; step();
    n_checks++;
    if (busy[5] !== 1'b0 || gnt !== '0 || free_cnt !== FC_W'(1)) begin
      n_errors++; $display("FAIL rel_cycle got busy5=%b gnt=%h free=%0d exp 0/00/1", busy[5], gnt, free_cnt);
    end
    rel = '0; step();
    n_checks++;
    if (gnt !== 8'h02 || gnt_ch !== 4'd5 || owner[5*PER_W +: PER_W] !== 3'd1) begin
      n_errors++; $display("FAIL regrant got gnt=%h ch=%0d own=%0d exp 02/5/1", gnt, gnt_ch, owner[5*PER_W +: PER_W]);
    end
    req = '0; step();
    // peripheral 3 tries to release channel 5, now owned by peripheral 1
    rel = 8'h08; rel_ch[3*CH_W +: CH_W] = 4'd5; step();
    n_checks++;
    if (err !== 1'b1 || busy[5] !== 1'b1 || owner[5*PER_W +: PER_W] !== 3'd1 || free_cnt !== '0) begin
      n_errors++; $display("FAIL illegal_rel got err=%b busy5=%b own=%0d free=%0d exp 1/1/1/0",
                           err, busy[5], owner[5*PER_W +: PER_W], free_cnt);
    end
    rel = '0; step();
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_pulse got=%b exp=0", err); end
    // free one channel so the bulk release also has a grant opportunity
    rel = 8'h10; rel_ch[4*CH_W +: CH_W] = 4'd15; step();
    rel = '0;
    n_checks++; if (free_cnt !== FC_W'(1)) begin n_errors++; $display("FAIL pre_relall_free got=%0d exp=1", free_cnt); end
    rel_all = 8'h01; req = 8'h01; rel = 8'h01; rel_ch[0 +: CH_W] = 4'd2; step();
    n_checks++;
    if (gnt !== '0 || err !== 1'b0 || busy[3:0] !== 4'h0 || free_cnt !== FC_W'(5)) begin
      n_errors++; $display("FAIL rel_all got gnt=%h err=%b busy=%h free=%0d exp 00/0/0/5", gnt, err, busy[3:0], free_cnt);
    end
    rel_all = '0; req = '0; rel = '0; step();
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rel_all_err got=%b exp=0", err); end
  endtask

  task automatic test_cap();
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) grant_to(0);
    req = 8'h03; step();
    n_checks++;
    if (gnt !== 8'h02 || gnt_ch !== 4'd4) begin
      n_errors++; $display("FAIL cap_skip got gnt=%h ch=%0d exp 02/4", gnt, gnt_ch);
    end
    req = 8'h01; rel = 8'h01; rel_ch[0 +: CH_W] = 4'd1; step();
    rel = '0;
    n_checks++;
    if (gnt !== '0 || busy[1] !== 1'b0) begin
      n_errors++; $display("FAIL cap_rel got gnt=%h busy1=%b exp 00/0", gnt, busy[1]);
    end
    step();
    n_checks++;
    if (gnt !== 8'h01 || gnt_ch !== 4'd1) begin
      n_errors++; $display("FAIL cap_regrant got gnt=%h ch=%0d exp 01/1", gnt, gnt_ch);
    end
    req = '0; step();
  endtask

  task automatic test_random();
    int lst[$];
    int c;
    rst = 1'b1; step(); rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      req = NP'($urandom);
      rel = '0; rel_all = '0;
      for (int p = 0; p < NP; p++) begin
        rel_all[p] = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 3) == 0) begin
          rel[p] = 1'b1;
          lst = {};
          for (int i = 0; i < NC; i++) if (m_owner[i] == p) lst.push_back(i);
          if (lst.size() > 0 && $urandom_range(0, 3) != 0) c = lst[$urandom_range(0, lst.size() - 1)];
          else c = $urandom_range(0, NC - 1);
          rel_ch[p*CH_W +: CH_W] = CH_W'(c);
        end
      end
      step();
      n_checks++; if (gnt !== e_gnt) begin n_errors++; $display("FAIL rnd_gnt cyc=%0d got=%h exp=%h", cyc, gnt, e_gnt); end
      n_checks++; if (gnt_ch !== CH_W'(e_gnt_ch)) begin n_errors++; $display("FAIL rnd_gnt_ch cyc=%0d got=%0d exp=%0d", cyc, gnt_ch, e_gnt_ch); end
      n_checks++; if (busy !== exp_busy()) begin n_errors++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, busy, exp_busy()); end
      n_checks++; if (owner !== exp_owner()) begin n_errors++; $display("FAIL rnd_owner cyc=%0d got=%h exp=%h", cyc, owner, exp_owner()); end
      n_checks++; if (free_cnt !== FC_W'(exp_free())) begin n_errors++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", cyc, free_cnt, exp_free()); end
      n_checks++; if (err !== e_err) begin n_errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, e_err); end
    end
    rst = 1'b0; req = '0; rel = '0; rel_all = '0;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_rotate();
    test_release_regrant();
    test_cap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
